// File: rtl/matrix_pkg.sv
// matrix_pkg: shared matrix geometry, scan-order encodings and the JPEG zigzag table.
package matrix_pkg;
  localparam int MAT_N = 8;
  localparam int MAT_SIZE = 64;
  typedef enum logic [1:0] {SCAN_RASTER, SCAN_TRANSPOSE, SCAN_ZIGZAG} scan_t;
  typedef enum logic {RD_IDLE, RD_STREAM} rd_state_t;
  localparam logic [5:0] ZIGZAG [MAT_SIZE] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };
endpackage

// File: rtl/scan_order_rom.sv
// scan_order_rom: maps a scan position to the raster index for the selected order.
module scan_order_rom
  import matrix_pkg::*;
(
  input  scan_t      order,
  input  logic [5:0] cnt,
  output logic [5:0] index
);
  // transpose swaps the row and column fields of the scan position
  always_comb
    index = order == SCAN_TRANSPOSE ? {cnt[2:0], cnt[5:3]} :
            order == SCAN_ZIGZAG    ? ZIGZAG[cnt] : cnt;
endmodule

// File: rtl/matrix_scan_buffer.sv
// matrix_scan_buffer: two-bank ping-pong capture of 8x8 matrices, re-emitted in a
// raster, transpose or zigzag scan over a valid/ready stream.
module matrix_scan_buffer
  import matrix_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ORDER  = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [5:0]        out_index,
  output logic              out_last,
  input  logic              out_ready,
  output logic [1:0]        bank_full
);
  localparam scan_t ORD = scan_t'(ORDER[1:0]);
  logic [DATA_W-1:0] mem [2][MAT_SIZE];
  logic [1:0] full;
  logic wr_bank, rd_bank, wr_en, rd_en, wr_done, rd_done;
  logic [5:0] wr_cnt, rd_cnt, scan_idx;
  rd_state_t state, state_nx;
  scan_order_rom u_rom (.order(ORD), .cnt(rd_cnt), .index(scan_idx));
  assign in_ready  = !full[wr_bank];
  assign bank_full = full;
  assign wr_en     = in_valid && in_ready;
  assign rd_en     = out_valid && out_ready;
  assign wr_done   = wr_en && wr_cnt == 6'd63;
  assign rd_done   = rd_en && rd_cnt == 6'd63;
  always_ff @(posedge clk)
    if (wr_en) mem[wr_bank][wr_cnt] <= in_data;
  // counters wrap naturally, so rd_cnt is already 0 whenever the reader idles
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      full    <= 2'b00;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_cnt  <= 6'd0;
      rd_cnt  <= 6'd0;
    end else begin
      if (wr_en) wr_cnt <= wr_cnt + 6'd1;
      if (wr_done) wr_bank <= !wr_bank;
      if (rd_en) rd_cnt <= rd_cnt + 6'd1;
      if (rd_done) rd_bank <= !rd_bank;
      full <= (full | ({1'b0, wr_done} << wr_bank)) & ~({1'b0, rd_done} << rd_bank);
    end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= RD_IDLE;
    else state <= state_nx;
  always_comb
    state_nx = state == RD_IDLE ? (full[rd_bank] ? RD_STREAM : RD_IDLE)
                                : (rd_done ? RD_IDLE : RD_STREAM);
  always_comb begin
    out_valid = state == RD_STREAM;
    out_last  = out_valid && rd_cnt == 6'd63;
    out_index = scan_idx;
    out_data  = mem[rd_bank][scan_idx];
  end
endmodule

// File: tb/tb_matrix_scan_buffer.sv
// tb_matrix_scan_buffer: drives one stimulus into raster, transpose and zigzag instances
// and checks every output beat against an independently built scan model.
module tb_matrix_scan_buffer;
  import matrix_pkg::*;
  logic clk = 1'b0, reset = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic in_ready [3];
  logic out_valid [3];
  logic [7:0] out_data [3];
  logic [5:0] out_index [3];
  logic out_last [3];
  logic [1:0] bank_full [3];
  int checks = 0, errors = 0;
  int done_ids [64];
  int done_cnt = 0;
  int rd_ptr [3], rd_k [3], last_cnt [3];
  logic [7:0] lg [3][64];
  bit stalled [3];
  logic [7:0] st_d [3];
  logic [5:0] st_i [3];
  int zz [64];
  logic [1:0] first_bf;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : gen_dut
    matrix_scan_buffer #(.DATA_W(8), .ORDER(g)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready[g]), .out_valid(out_valid[g]), .out_data(out_data[g]),
      .out_index(out_index[g]), .out_last(out_last[g]), .out_ready(out_ready),
      .bank_full(bank_full[g]));
  end

  task automatic build_zz();
    int k = 0;
    for (int s = 0; s < 15; s++)
      if (s % 2 == 0)
        for (int r = (s < 8 ? s : 7); r >= (s > 7 ? s - 7 : 0); r--) begin zz[k] = r * 8 + (s - r); k++; end
      else
        for (int r = (s > 7 ? s - 7 : 0); r <= (s < 8 ? s : 7); r++) begin zz[k] = r * 8 + (s - r); k++; end
  endtask

  function automatic int exp_index(int ord, int k);
    return ord == 0 ? k : ord == 1 ? (k % 8) * 8 + k / 8 : zz[k];
  endfunction

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (reset) begin
        for (int g = 0; g < 3; g++) stalled[g] = 0;
      end else for (int g = 0; g < 3; g++) begin
        if (stalled[g]) begin
          checks++;
          if (!out_valid[g] || out_data[g] !== st_d[g] || out_index[g] !== st_i[g]) begin
            errors++;
            $display("FAIL stall_hold[%0d]: valid=%0b data=%0d index=%0d, required valid=1 data=%0d index=%0d",
                     g, out_valid[g], out_data[g], out_index[g], st_d[g], st_i[g]);
          end
        end
        if (out_valid[g]) begin
          checks++;
          if (rd_ptr[g] >= done_cnt) begin
            errors++;
            $display("FAIL spurious_valid[%0d]: out_valid=1 with no complete matrix pending", g);
          end else begin
            int ei = exp_index(g, rd_k[g]);
            int ed = (done_ids[rd_ptr[g]] * 64 + ei) % 256;
            if (out_index[g] !== 6'(ei) || out_data[g] !== 8'(ed) || out_last[g] !== (rd_k[g] == 63)) begin
              errors++;
              $display("FAIL stream[%0d] k=%0d: index=%0d data=%0d last=%0b, required index=%0d data=%0d last=%0b",
                       g, rd_k[g], out_index[g], out_data[g], out_last[g], ei, ed, rd_k[g] == 63);
            end
          end
          if (out_ready) begin
            lg[g][rd_k[g]] = out_data[g];
            stalled[g] = 0;
            if (rd_k[g] == 63) begin rd_k[g] = 0; rd_ptr[g]++; last_cnt[g]++; end
            else rd_k[g]++;
          end else begin
            stalled[g] = 1; st_d[g] = out_data[g]; st_i[g] = out_index[g];
          end
        end else stalled[g] = 0;
      end
    end
  endtask

  task automatic write_matrix(input int m, input int n);
    for (int i = 0; i < n; i++) begin
      int t = 0;
      in_valid = 1'b1;
      in_data = 8'((m * 64 + i) % 256);
      @(negedge clk);
      while (!in_ready[0]) begin
        t++;
        if (t > 2000) begin
          checks++; errors++;
          $display("FAIL write_timeout: matrix %0d element %0d never accepted", m, i);
          in_valid = 1'b0;
          return;
        end
        @(negedge clk);
      end
      if (i == 0) first_bf = bank_full[0];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (n == 64) begin done_ids[done_cnt] = m; done_cnt++; end
  endtask

  task automatic wait_drain();
    int t = 0;
    bit busy = 1;
    while (busy) begin
      @(negedge clk);
      busy = 0;
      for (int g = 0; g < 3; g++) if (rd_ptr[g] != done_cnt || out_valid[g]) busy = 1;
      t++;
      if (t > 3000) begin
        checks++; errors++;
        $display("FAIL drain_timeout: rd_ptr=%0d/%0d/%0d, required %0d", rd_ptr[0], rd_ptr[1], rd_ptr[2], done_cnt);
        busy = 0;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int g = 0; g < 3; g++) begin
      checks++;
      if (in_ready[g] !== 1'b1 || out_valid[g] !== 1'b0 || out_last[g] !== 1'b0 ||
          out_index[g] !== 6'd0 || bank_full[g] !== 2'b00) begin
        errors++;
        $display("FAIL reset_state[%0d]: in_ready=%0b out_valid=%0b out_last=%0b out_index=%0d bank_full=%b, required 1 0 0 0 00",
                 g, in_ready[g], out_valid[g], out_last[g], out_index[g], bank_full[g]);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_passthrough();
    out_ready = 1'b1;
    write_matrix(0, 64);
    checks++;
    if (bank_full[0] !== 2'b01 || out_valid[0] !== 1'b0) begin
      errors++;
      $display("FAIL fill_edge1: bank_full=%b out_valid=%0b, required 01 0", bank_full[0], out_valid[0]);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid[0] !== 1'b1 || out_index[0] !== 6'd0) begin
      errors++;
      $display("FAIL fill_edge2: out_valid=%0b out_index=%0d, required 1 0", out_valid[0], out_index[0]);
    end
    wait_drain();
    for (int g = 0; g < 3; g++) begin
      checks++;
      if (rd_ptr[g] != 1 || last_cnt[g] != 1) begin
        errors++;
        $display("FAIL passthrough_count[%0d]: matrices=%0d lasts=%0d, required 1 1", g, rd_ptr[g], last_cnt[g]);
      end
    end
    for (int k = 0; k < 64; k++) begin
      checks++;
      if (lg[0][k] !== 8'(k)) begin
        errors++;
        $display("FAIL raster_seq[%0d]: got %0d, required %0d", k, lg[0][k], k);
      end
    end
  endtask

  task automatic test_zigzag();
    int pos [9] = '{0, 1, 2, 3, 4, 5, 61, 62, 63};
    int val [9] = '{0, 1, 8, 16, 9, 2, 55, 62, 63};
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (lg[2][pos[i]] !== 8'(val[i])) begin
        errors++;
        $display("FAIL zigzag_seq[%0d]: got %0d, required %0d", pos[i], lg[2][pos[i]], val[i]);
      end
    end
  endtask

  task automatic test_transpose();
    int pos [6] = '{0, 1, 7, 8, 9, 63};
    int val [6] = '{0, 8, 56, 1, 9, 63};
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (lg[1][pos[i]] !== 8'(val[i])) begin
        errors++;
        $display("FAIL transpose_seq[%0d]: got %0d, required %0d", pos[i], lg[1][pos[i]], val[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    write_matrix(1, 64);
    write_matrix(2, 64);
    @(negedge clk);
    checks++;
    if (in_ready[0] !== 1'b0 || bank_full[0] !== 2'b11 || out_valid[0] !== 1'b1) begin
      errors++;
      $display("FAIL both_full: in_ready=%0b bank_full=%b out_valid=%0b, required 0 11 1",
               in_ready[0], bank_full[0], out_valid[0]);
    end
    @(posedge clk); #1;
    fork
      write_matrix(3, 64);
      begin repeat (5) @(posedge clk); #1; out_ready = 1'b1; end
    join
    checks++;
    if (first_bf !== 2'b01) begin
      errors++;
      $display("FAIL c_after_free: bank_full at first accept of C=%b, required 01", first_bf);
    end
    wait_drain();
    checks++;
    if (rd_ptr[0] != 4 || last_cnt[0] != 4) begin
      errors++;
      $display("FAIL backpressure_count: matrices=%0d lasts=%0d, required 4 4", rd_ptr[0], last_cnt[0]);
    end
  endtask

  task automatic test_random_ready();
    fork
      begin write_matrix(4, 64); write_matrix(5, 64); write_matrix(6, 64); end
      repeat (400) begin @(posedge clk); #1; out_ready = 1'($urandom_range(0, 1)); end
    join
    out_ready = 1'b1;
    wait_drain();
    for (int g = 0; g < 3; g++) begin
      checks++;
      if (rd_ptr[g] != 7 || last_cnt[g] != 7) begin
        errors++;
        $display("FAIL random_count[%0d]: matrices=%0d lasts=%0d, required 7 7", g, rd_ptr[g], last_cnt[g]);
      end
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    write_matrix(7, 64);
    fork
      write_matrix(8, 30);
      begin
        int t = 0;
        while (rd_k[0] != 20 && t < 500) begin @(posedge clk); #1; t++; end
        out_ready = 1'b0;
      end
    join
    #2 reset = 1'b1;
    #1;
    for (int g = 0; g < 3; g++) begin
      checks++;
      if (out_valid[g] !== 1'b0 || bank_full[g] !== 2'b00 || in_ready[g] !== 1'b1 || out_last[g] !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid[%0d]: out_valid=%0b bank_full=%b in_ready=%0b out_last=%0b, required 0 00 1 0",
                 g, out_valid[g], bank_full[g], in_ready[g], out_last[g]);
      end
      rd_ptr[g] = 0; rd_k[g] = 0; last_cnt[g] = 0;
    end
    done_cnt = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    out_ready = 1'b1;
    write_matrix(9, 64);
    wait_drain();
    checks++;
    if (rd_ptr[0] != 1 || lg[0][0] !== 8'd64 || lg[0][63] !== 8'd127) begin
      errors++;
      $display("FAIL after_reset: matrices=%0d first=%0d last=%0d, required 1 64 127", rd_ptr[0], lg[0][0], lg[0][63]);
    end
  endtask

  initial begin
    build_zz();
    fork monitor(); join_none
    test_reset();
    test_passthrough();
    test_zigzag();
    test_transpose();
    test_backpressure();
    test_random_ready();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
